// File: rtl/ec2_pkg.sv
// Shared definitions for the EC2 operator-input front end.
// Holds the debounce state encoding and default sizing constants.
package ec2_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } db_state_e;

    localparam int EC2_DEBOUNCE_CYCLES = 16;
    localparam int EC2_DEPTH           = 4;
    localparam int EC2_CNT_W           = 16;

endpackage

// File: rtl/ec2_debounce.sv
// Key/switch synchroniser and debounce FSM for the EC2 input front end.
// Ports: clk, rst_n (async low), key_raw, sw_raw[7:0] in;
//        push (one-cycle strobe on an accepted press), sync_sw[7:0] out.
module ec2_debounce
    import ec2_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = EC2_DEBOUNCE_CYCLES,
    parameter int CNT_W           = EC2_CNT_W
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_raw,
    input  logic [7:0] sw_raw,
    output logic       push,
    output logic [7:0] sync_sw
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             key_s1_q, key_s2_q;
    logic [7:0]       sw_s1_q, sw_s2_q;
    db_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // push is decoded from registered state so the FIFO write lands
    // on the same edge the FSM leaves PRESS_WAIT.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        push    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (key_s2_q) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!key_s2_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    push    = 1'b1;
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                if (!key_s2_q) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (key_s2_q) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_s1_q <= 1'b0;
            key_s2_q <= 1'b0;
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
            state_q  <= IDLE;
            cnt_q    <= '0;
        end else begin
            key_s1_q <= key_raw;
            key_s2_q <= key_s1_q;
            sw_s1_q  <= sw_raw;
            sw_s2_q  <= sw_s1_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
        end
    end

    assign sync_sw = sw_s2_q;

endmodule

// File: rtl/ec2_input_frontend.sv
// EC2 operator-input front end: debounced key captures switch bytes into a FIFO.
// Ports: Clock, Reset (async low), KeyRaw, SwRaw[7:0], Ack in;
//        Enter, Input[7:0], Count, Overflow (sticky) out.
module ec2_input_frontend
    import ec2_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = EC2_DEBOUNCE_CYCLES,
    parameter int DEPTH           = EC2_DEPTH,
    parameter int CNT_W           = EC2_CNT_W
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     KeyRaw,
    input  logic [7:0]               SwRaw,
    input  logic                     Ack,
    output logic                     Enter,
    output logic [7:0]               Input,
    output logic [$clog2(DEPTH):0]   Count,
    output logic                     Overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic          push;
    logic [7:0]    sync_sw;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic          overflow_q, overflow_d;

    logic [PW-1:0] count;
    logic          empty;
    logic          full;
    logic          pop;

    ec2_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_debounce (
        .clk     (Clock),
        .rst_n   (Reset),
        .key_raw (KeyRaw),
        .sw_raw  (SwRaw),
        .push    (push),
        .sync_sw (sync_sw)
    );

    // Extra pointer MSB separates full from empty.
    assign count = wr_ptr_q - rd_ptr_q;
    assign empty = (count == '0);
    assign full  = (count == PW'(DEPTH));
    assign pop   = Ack && !empty;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        mem_d      = mem_q;
        overflow_d = overflow_q;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        // When full, a same-edge pop frees the head slot, which is
        // exactly the slot the write pointer indexes.
        if (push) begin
            if (!full || pop) begin
                mem_d[wr_ptr_q[AW-1:0]] = sync_sw;
                wr_ptr_d                = wr_ptr_q + 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
            mem_q      <= mem_d;
        end
    end

    assign Enter    = !empty;
    assign Input    = empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
    assign Count    = count;
    assign Overflow = overflow_q;

endmodule

// File: tb/tb_ec2_input_frontend.sv
// Scoreboard bench for ec2_input_frontend with default parameters.
// Stimulus queues expected bytes; a negedge monitor checks each consumed head.
module tb_ec2_input_frontend;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       KeyRaw;
    logic [7:0] SwRaw;
    logic       Ack;
    logic       Enter;
    logic [7:0] Input;
    logic [2:0] Count;
    logic       Overflow;

    int n_total = 0;
    int n_pass  = 0;
    logic [7:0] exp_q [$];

    ec2_input_frontend dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .KeyRaw   (KeyRaw),
        .SwRaw    (SwRaw),
        .Ack      (Ack),
        .Enter    (Enter),
        .Input    (Input),
        .Count    (Count),
        .Overflow (Overflow)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string nm, input int act, input int req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, req);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic pulse_ack();
        Ack = 1'b1;
        @(posedge Clock);
        #1;
        Ack = 1'b0;
        cyc(2);
    endtask

    task automatic press(input logic [7:0] b, input bit accepted);
        SwRaw = b;
        if (accepted) exp_q.push_back(b);
        cyc(3);
        KeyRaw = 1'b1;
        cyc(22);
        KeyRaw = 1'b0;
        cyc(22);
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_enter"}, Enter, 0);
        chk({nm, "_input"}, Input, 0);
        chk({nm, "_count"}, Count, 0);
    endtask

    // Monitor: Ack high at the negedge means the head is consumed next edge.
    always @(negedge Clock) begin
        if (Reset && Ack && Enter) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL sb_extra: got %0h expected none", Input);
            end else begin
                chk("sb_head", Input, exp_q.pop_front());
            end
        end
    end

    initial begin
        int n;
        int bad;
        Reset  = 1'b0;
        KeyRaw = 1'b0;
        SwRaw  = 8'h00;
        Ack    = 1'b0;
        cyc(4);
        chk_idle("rst");
        chk("rst_ovf", Overflow, 0);
        Reset = 1'b1;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            cyc(1);
            if (Enter || Input != 0 || Count != 0 || Overflow) bad++;
        end
        chk("idle50_bad_cycles", bad, 0);

        // Clean press: latency and head byte.
        SwRaw = 8'hA5;
        exp_q.push_back(8'hA5);
        cyc(3);
        KeyRaw = 1'b1;
        n = 0;
        while (n < 100) begin
            @(posedge Clock);
            n++;
            #1;
            if (Enter) break;
        end
        chk("latency_edges", n - 1, 18);
        chk("lat_input", Input, 8'hA5);
        chk("lat_count", Count, 1);
        cyc(11);
        KeyRaw = 1'b0;
        cyc(25);
        chk("lat_no_repeat", Count, 1);
        pulse_ack();
        chk_idle("after_ack");

        // Bouncy press then bouncy release: one push only.
        SwRaw = 8'h3C;
        exp_q.push_back(8'h3C);
        for (int i = 0; i < 40; i++) begin
            KeyRaw = ((i / 3) % 2) == 0;
            cyc(1);
        end
        KeyRaw = 1'b1;
        cyc(20);
        chk("bounce_push", Count, 1);
        for (int i = 0; i < 30; i++) begin
            KeyRaw = ((i / 3) % 2) == 1;
            cyc(1);
        end
        KeyRaw = 1'b0;
        cyc(30);
        chk("bounce_single", Count, 1);
        pulse_ack();
        chk("bounce_drained", Count, 0);

        // Overflow: fifth press dropped.
        press(8'h01, 1'b1);
        press(8'h02, 1'b1);
        press(8'h03, 1'b1);
        press(8'h04, 1'b1);
        chk("full_no_ovf", Overflow, 0);
        press(8'h05, 1'b0);
        chk("ovf_count", Count, 4);
        chk("ovf_flag", Overflow, 1);
        for (int i = 0; i < 4; i++) pulse_ack();
        chk_idle("ovf_drained");
        chk("ovf_sticky", Overflow, 1);

        Reset = 1'b0;
        cyc(2);
        chk("ovf_cleared", Overflow, 0);
        Reset = 1'b1;
        cyc(2);

        // Full FIFO with push and pop on the same edge.
        press(8'h11, 1'b1);
        press(8'h22, 1'b1);
        press(8'h33, 1'b1);
        press(8'h44, 1'b1);
        chk("full_count", Count, 4);
        SwRaw = 8'h77;
        exp_q.push_back(8'h77);
        cyc(3);
        KeyRaw = 1'b1;
        repeat (18) @(posedge Clock);
        #1;
        Ack = 1'b1;
        @(posedge Clock);
        #1;
        Ack = 1'b0;
        chk("same_edge_count", Count, 4);
        chk("same_edge_ovf", Overflow, 0);
        chk("same_edge_head", Input, 8'h22);
        cyc(5);
        KeyRaw = 1'b0;
        cyc(22);
        for (int i = 0; i < 4; i++) pulse_ack();
        chk_idle("same_edge_drained");

        // Ack while empty is ignored.
        pulse_ack();
        chk_idle("ack_empty");
        press(8'h5A, 1'b1);
        chk("ack_empty_ptrs", Input, 8'h5A);
        press(8'h6B, 1'b0);
        chk("pre_rst_count", Count, 2);

        // Async reset mid-PRESS_WAIT with data queued.
        SwRaw = 8'hC3;
        cyc(3);
        KeyRaw = 1'b1;
        cyc(10);
        #2;
        Reset = 1'b0;
        #1;
        chk("async_enter", Enter, 0);
        chk("async_input", Input, 0);
        chk("async_count", Count, 0);
        chk("async_ovf", Overflow, 0);
        exp_q.delete();
        KeyRaw = 1'b0;
        cyc(3);
        Reset = 1'b1;
        cyc(40);
        chk("no_push_after_rst", Count, 0);
        chk("sb_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
